// File: rtl/alu_seq.sv
// ============================================================================
// alu_seq -- sequential ALU with iterative multiply and valid/ready handshakes
//
// Accepts one operation per handshake and presents a registered result plus
// flags behind an output valid/ready handshake. Logic, add/sub and shift
// operations finish at the accept edge. MUL runs an iterative shift-add
// multiply, one iteration per clock edge, for WIDTH iterations.
//
// Parameters:
//   WIDTH      data width in bits (>= 2)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operands and op are valid
//   in_ready   block can accept an operation (combinational)
//   a, b       operands; b is also the shift amount
//   op         000 AND, 001 ADD, 010 SUB, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL
//   ci         carry-in, used by ADD only
//   out_valid  result and flags are valid
//   out_ready  consumer takes the result
//   result     registered result
//   neg, zero, carry, ovf   registered flags describing result
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             neg,
    output logic             zero,
    output logic             carry,
    output logic             ovf
);

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MUL      = 2'd1,
        S_MUL_WAIT = 2'd2
    } state_t;

    localparam int             CW    = $clog2(WIDTH);
    localparam int             MSB   = WIDTH - 1;
    localparam logic [CW-1:0]  LAST  = CW'(WIDTH - 1);
    localparam logic [WIDTH:0] W_VAL = (WIDTH + 1)'(WIDTH);

    state_t state, state_next;

    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_step;
    logic [2*WIDTH-1:0]   prod;

    logic out_free;
    logic accept;
    logic mul_start;
    logic alu_load;
    logic mul_load;

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    // The output register is free when empty or being drained on this edge.
    assign out_free  = !out_valid || out_ready;
    assign in_ready  = (state == S_IDLE) && out_free && !rst;
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (op == OP_MUL);
    assign alu_load  = accept && (op != OP_MUL);

    // ------------------------------------------------------------------------
    // Single-cycle ALU path
    // ------------------------------------------------------------------------
    logic [WIDTH:0]       sum_add;
    logic [WIDTH:0]       sum_sub;
    logic [2*WIDTH-1:0]   shl_ext;
    logic [2*WIDTH-1:0]   shr_ext;
    logic [CW-1:0]        sh;
    logic                 sh_big;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c;
    logic                 alu_o;

    assign sum_add = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
    assign sum_sub = {1'b0, a} + {1'b0, ~b} + (WIDTH + 1)'(1);

    // Any shift amount >= WIDTH clears everything; below that, b fits in CW
    // bits. Shifting into a double-width vector leaves the last bit shifted
    // out sitting right next to the result field, and a zero shift puts a
    // zero there, so carry needs no special case for b==0.
    assign sh_big  = ({1'b0, b} >= W_VAL);
    assign sh      = b[CW-1:0];
    assign shl_ext = {{WIDTH{1'b0}}, a} << sh;
    assign shr_ext = {a, {WIDTH{1'b0}}} >> sh;

    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_o   = 1'b0;
        case (op_t'(op))
            OP_AND: alu_res = a & b;
            OP_ADD: begin
                alu_res = sum_add[WIDTH-1:0];
                alu_c   = sum_add[WIDTH];
                alu_o   = (a[MSB] == b[MSB]) && (sum_add[MSB] != a[MSB]);
            end
            OP_SUB: begin
                alu_res = sum_sub[WIDTH-1:0];
                alu_c   = sum_sub[WIDTH];
                alu_o   = (a[MSB] != b[MSB]) && (sum_sub[MSB] != a[MSB]);
            end
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_SHL: begin
                if (!sh_big) begin
                    alu_res = shl_ext[WIDTH-1:0];
                    alu_c   = shl_ext[WIDTH];
                end
            end
            OP_SHR: begin
                if (!sh_big) begin
                    alu_res = shr_ext[2*WIDTH-1:WIDTH];
                    alu_c   = shr_ext[WIDTH-1];
                end
            end
            OP_MUL: ;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Multiply FSM
    // ------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so that
    // every register samples its inputs from before the edge.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        mul_load   = 1'b0;
        case (state)
            S_IDLE: begin
                if (mul_start) state_next = S_MUL;
            end
            S_MUL: begin
                if (cnt == LAST) begin
                    if (out_free) begin
                        mul_load   = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_MUL_WAIT;
                    end
                end
            end
            S_MUL_WAIT: begin
                if (out_free) begin
                    mul_load   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // One shift-add iteration: add the shifted multiplicand when the current
    // multiplier LSB is set. On the final iteration the product is acc_step;
    // once parked in MUL_WAIT it is held in acc.
    assign acc_step = mplier[0] ? (acc + mcand) : acc;
    assign prod     = (state == S_MUL) ? acc_step : acc;

    always_ff @(posedge clk) begin
        if (rst)                  cnt <= '0;
        else if (mul_start)       cnt <= '0;
        else if (state == S_MUL)  cnt <= cnt + 1'b1;
    end

    // NOTE: the operand and accumulator registers carry no reset; they are
    // always written at the accept edge before any iteration reads them.
    always_ff @(posedge clk) begin
        if (mul_start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
        end else if (state == S_MUL) begin
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    // ------------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            neg       <= 1'b0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
        end else if (alu_load) begin
            out_valid <= 1'b1;
            result    <= alu_res;
            neg       <= alu_res[MSB];
            zero      <= (alu_res == '0);
            carry     <= alu_c;
            ovf       <= alu_o;
        end else if (mul_load) begin
            out_valid <= 1'b1;
            result    <= prod[WIDTH-1:0];
            neg       <= prod[MSB];
            zero      <= (prod[WIDTH-1:0] == '0);
            carry     <= |prod[2*WIDTH-1:WIDTH];
            ovf       <= 1'b0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// ============================================================================
// tb_alu_seq -- self-checking bench for alu_seq (WIDTH=4)
//
// Directed scenarios with hand-derived expected values, followed by a
// randomized run checked against an arithmetic reference model. Observed
// outputs are packed as {result, neg, zero, carry, ovf}.
// ============================================================================
module tb_alu_seq;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    localparam logic [2:0] AND_OP = 3'd0, ADD_OP = 3'd1, SUB_OP = 3'd2,
                           OR_OP  = 3'd3, XOR_OP = 3'd4, SHL_OP = 3'd5,
                           SHR_OP = 3'd6, MUL_OP = 3'd7;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         ci;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         neg, zero, carry, ovf;
    logic [W+3:0] obs;

    int checks   = 0;
    int failures = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .neg       (neg),
        .zero      (zero),
        .carry     (carry),
        .ovf       (ovf)
    );

    assign obs = {result, neg, zero, carry, ovf};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the operation rules.
    function automatic logic [W+3:0] model(input int o, input int x, input int y, input int cin);
        int r, c, v, sx, sy, s, p;
        r = 0; c = 0; v = 0;
        sx = (x >= MOD/2) ? x - MOD : x;
        sy = (y >= MOD/2) ? y - MOD : y;
        case (o)
            0: r = x & y;
            1: begin
                s = x + y + cin; r = s % MOD; c = (s >= MOD) ? 1 : 0;
                s = sx + sy + cin; v = (s > MOD/2 - 1 || s < -MOD/2) ? 1 : 0;
            end
            2: begin
                r = (x - y + MOD) % MOD; c = (x >= y) ? 1 : 0;
                s = sx - sy; v = (s > MOD/2 - 1 || s < -MOD/2) ? 1 : 0;
            end
            3: r = x | y;
            4: r = x ^ y;
            5: begin
                if (y == 0)      r = x;
                else if (y >= W) r = 0;
                else begin r = (x << y) % MOD; c = (x >> (W - y)) & 1; end
            end
            6: begin
                if (y == 0)      r = x;
                else if (y >= W) r = 0;
                else begin r = x >> y; c = (x >> (y - 1)) & 1; end
            end
            default: begin
                p = x * y; r = p % MOD; c = (p >= MOD) ? 1 : 0;
            end
        endcase
        return {r[W-1:0], (r >= MOD/2), (r == 0), c[0], v[0]};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input logic cin);
        in_valid = 1'b1;
        op = o; a = x; b = y; ci = cin;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset;
        rst = 1'b1;
        repeat (2) step();
        checks++;
        if (out_valid !== 1'b0 || obs !== '0) begin
            failures++;
            $display("FAIL reset_state: out_valid=%b obs=%b, expected 0/%b", out_valid, obs, 8'b0);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready_low: in_ready=%b, expected 0", in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready_high: in_ready=%b, expected 1", in_ready);
        end
    endtask

    task automatic test_add;
        out_ready = 1'b1;
        drive(ADD_OP, 4'b0111, 4'b0010, 1'b0);
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || obs !== 8'b1001_1001) begin
            failures++;
            $display("FAIL add_7_2: out_valid=%b obs=%b, expected 1/%b", out_valid, obs, 8'b1001_1001);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL add_drain: out_valid=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_sub;
        drive(SUB_OP, 4'b0101, 4'b0101, 1'b1);
        step();
        checks++;
        if (out_valid !== 1'b1 || obs !== 8'b0000_0110) begin
            failures++;
            $display("FAIL sub_5_5: out_valid=%b obs=%b, expected 1/%b", out_valid, obs, 8'b0000_0110);
        end
        drive(SUB_OP, 4'b0001, 4'b0010, 1'b0);
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || obs !== 8'b1111_1000) begin
            failures++;
            $display("FAIL sub_1_2: out_valid=%b obs=%b, expected 1/%b", out_valid, obs, 8'b1111_1000);
        end
        step();
    endtask

    task automatic test_shift;
        logic [2:0]   t_op  [4] = '{SHL_OP, SHR_OP, SHL_OP, SHR_OP};
        logic [W-1:0] t_a   [4] = '{4'b1101, 4'b1101, 4'b1101, 4'b0111};
        logic [W-1:0] t_b   [4] = '{4'b0011, 4'b0011, 4'b0100, 4'b0000};
        logic [W+3:0] t_exp [4] = '{8'b1000_1000, 8'b0001_0010, 8'b0000_0100, 8'b0111_0000};
        for (int i = 0; i < 4; i++) begin
            drive(t_op[i], t_a[i], t_b[i], 1'b0);
            step();
            checks++;
            if (out_valid !== 1'b1 || obs !== t_exp[i]) begin
                failures++;
                $display("FAIL shift_%0d: out_valid=%b obs=%b, expected 1/%b", i, out_valid, obs, t_exp[i]);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_mul;
        drive(MUL_OP, 4'b0111, 4'b0011, 1'b0);
        step();
        in_valid = 1'b0;
        for (int k = 0; k < W - 1; k++) begin
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL mul_busy_%0d: out_valid=%b in_ready=%b, expected 0/0", k, out_valid, in_ready);
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL mul_busy_last: out_valid=%b in_ready=%b, expected 0/0", out_valid, in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || obs !== 8'b0101_0010 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mul_7_3: out_valid=%b obs=%b in_ready=%b, expected 1/%b/1",
                     out_valid, obs, in_ready, 8'b0101_0010);
        end
        step();
    endtask

    task automatic test_backpressure;
        logic [W+3:0] e1, e2;
        e1 = model(4, 10, 6, 0);
        e2 = model(4, 3, 5, 0);
        out_ready = 1'b0;
        drive(XOR_OP, 4'd10, 4'd6, 1'b0);
        step();
        drive(XOR_OP, 4'd3, 4'd5, 1'b0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid !== 1'b1 || obs !== e1 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold_%0d: out_valid=%b obs=%b in_ready=%b, expected 1/%b/0",
                         k, out_valid, obs, in_ready, e1);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release_ready: in_ready=%b, expected 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || obs !== e2) begin
            failures++;
            $display("FAIL bp_second: out_valid=%b obs=%b, expected 1/%b", out_valid, obs, e2);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain: out_valid=%b, expected 0", out_valid);
        end
    endtask

    // A multiply can only be accepted into an empty or draining output
    // register, so here the MUL starts on a drain edge and its result is
    // then held under backpressure.
    task automatic test_mul_drain;
        logic [W+3:0] e;
        e = model(7, 5, 6, 0);
        out_ready = 1'b0;
        drive(XOR_OP, 4'b1111, 4'b0001, 1'b0);
        step();
        drive(MUL_OP, 4'd5, 4'd6, 1'b0);
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL muld_drained: out_valid=%b, expected 0", out_valid);
        end
        repeat (W - 1) step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL muld_early: out_valid=%b, expected 0", out_valid);
        end
        step();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid !== 1'b1 || obs !== e || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL muld_hold_%0d: out_valid=%b obs=%b in_ready=%b, expected 1/%b/0",
                         k, out_valid, obs, in_ready, e);
            end
            step();
        end
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_mul;
        int seen;
        drive(MUL_OP, 4'b0111, 4'b0011, 1'b0);
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || obs !== '0) begin
            failures++;
            $display("FAIL rst_mid_mul_state: out_valid=%b obs=%b, expected 0/%b", out_valid, obs, 8'b0);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_mul_ready: in_ready=%b, expected 1", in_ready);
        end
        seen = 0;
        repeat (W + 3) begin
            step();
            if (out_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL rst_mid_mul_ghost: out_valid high %0d cycles, expected 0", seen);
        end
    endtask

    task automatic test_random;
        int o, x, y, c, lat;
        logic [W+3:0] e;
        for (int i = 0; i < 150; i++) begin
            o = $urandom_range(0, 7);
            x = $urandom_range(0, MOD - 1);
            y = $urandom_range(0, MOD - 1);
            c = $urandom_range(0, 1);
            e = model(o, x, y, c);
            out_ready = 1'b1;
            drive(3'(o), W'(x), W'(y), c[0]);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL rnd_ready_%0d: in_ready=%b, expected 1", i, in_ready);
            end
            step();
            in_valid = 1'b0;
            if (o == 7) begin
                lat = 0;
                while (out_valid !== 1'b1 && lat < W + 4) begin
                    step();
                    lat++;
                end
                checks++;
                if (lat != W) begin
                    failures++;
                    $display("FAIL rnd_mul_latency_%0d: latency=%0d, expected %0d", i, lat, W);
                end
            end
            checks++;
            if (out_valid !== 1'b1 || obs !== e) begin
                failures++;
                $display("FAIL rnd_%0d op=%0d a=%0d b=%0d ci=%0d: out_valid=%b obs=%b, expected 1/%b",
                         i, o, x, y, c, out_valid, obs, e);
            end
            if ($urandom_range(0, 3) == 0) begin
                out_ready = 1'b0;
                repeat (2) step();
                checks++;
                if (out_valid !== 1'b1 || obs !== e) begin
                    failures++;
                    $display("FAIL rnd_stall_%0d: out_valid=%b obs=%b, expected 1/%b", i, out_valid, obs, e);
                end
            end
        end
        out_ready = 1'b1;
        step();
    endtask

    // ------------------------------------------------------------------------
    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; op = '0; ci = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_shift();
        test_mul();
        test_backpressure();
        test_mul_drain();
        test_reset_mid_mul();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
